// File: rtl/spi_flash_resp.sv
// SPI-flash READ (0x03) responder, mode 0, MSB first. SCK/CS/MOSI are oversampled
// in clk; bytes are fetched through a one-outstanding read handshake and streamed on MISO.
module spi_flash_resp #(
  parameter int          ADDR_W      = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  READ_CMD    = 8'h03
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_flash_clk,
  input  logic              spi_flash_cs,
  input  logic              spi_flash_mosi,
  output logic              spi_flash_miso,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rd_rvalid,
  input  logic [7:0]        mem_rd_rdata,
  output logic              busy,
  output logic              cmd_err,
  output logic              underrun
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, FETCH, DATA, IGNORE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_s, cs_s, mosi_s, sck_p, cs_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_p     <= 1'b0;
      cs_p      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_flash_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_flash_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_flash_mosi};
      sck_p     <= sck_s;
      cs_p      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic sck_rise, sck_fall, cs_fall;
  assign sck_rise = ~cs_s & sck_s & ~sck_p;
  assign sck_fall = ~cs_s & ~sck_s & sck_p;
  assign cs_fall  = cs_p & ~cs_s;

  logic [4:0]        bit_cnt;
  logic [23:0]       in_sr, in_nxt;
  logic [ADDR_W-1:0] addr, addr_inc, issue_addr;
  logic [7:0]        out_sr, nxt_byte, load_byte;
  logic [2:0]        out_cnt;
  logic              buf_full, req_q, awaiting, drop;

  assign in_nxt   = {in_sr[22:0], mosi_s};
  assign addr_inc = addr + ADDR_W'(1);

  logic cmd_done, cmd_bad, addr_done, load, rsp_arrive, rsp_ok, have_byte;
  logic in_flight, req_evt, issue, drop_set;

  assign cmd_done   = (state == CMD) && sck_rise && (bit_cnt == 5'd7);
  assign cmd_bad    = cmd_done && (in_nxt[7:0] != READ_CMD);
  assign addr_done  = (state == ADDR) && sck_rise && (bit_cnt == 5'd23);
  assign load       = sck_fall && ((state == FETCH) || ((state == DATA) && (out_cnt == 3'd7)));
  assign rsp_arrive = mem_rd_rvalid && awaiting;
  assign rsp_ok     = rsp_arrive && !drop;
  // A response landing on the load cycle is forwarded straight to the shifter.
  assign have_byte  = buf_full || rsp_ok;
  assign load_byte  = buf_full ? nxt_byte : (rsp_ok ? mem_rd_rdata : 8'hFF);
  assign in_flight  = mem_rd_valid || awaiting;
  assign req_evt    = addr_done || load;
  assign issue      = (req_evt || req_q) && !in_flight && !cs_s;
  assign issue_addr = addr_done ? in_nxt[ADDR_W-1:0] : (load ? addr_inc : addr);
  // Whatever is in flight when CS rises or the byte is skipped is stale.
  assign drop_set   = in_flight && (cs_s || (load && !have_byte));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = CMD;
      CMD:     if (cmd_done) state_nxt = cmd_bad ? IGNORE : ADDR;
      ADDR:    if (addr_done) state_nxt = FETCH;
      FETCH:   if (load) state_nxt = DATA;
      default: state_nxt = state;
    endcase
    if (cs_s) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_flash_miso <= 1'b0;
      mem_rd_valid   <= 1'b0;
      mem_rd_addr    <= '0;
      cmd_err        <= 1'b0;
      underrun       <= 1'b0;
      bit_cnt        <= '0;
      in_sr          <= '0;
      addr           <= '0;
      out_sr         <= '0;
      out_cnt        <= '0;
      nxt_byte       <= '0;
      buf_full       <= 1'b0;
      req_q          <= 1'b0;
      awaiting       <= 1'b0;
      drop           <= 1'b0;
    end else begin
      cmd_err  <= cmd_bad;
      underrun <= load && !have_byte;

      if (mem_rd_valid && mem_rd_ready) mem_rd_valid <= 1'b0;
      else if (issue) begin
        mem_rd_valid <= 1'b1;
        mem_rd_addr  <= issue_addr;
      end

      if (mem_rd_valid && mem_rd_ready) awaiting <= 1'b1;
      else if (mem_rd_rvalid)           awaiting <= 1'b0;

      if (rsp_arrive)    drop <= 1'b0;
      else if (drop_set) drop <= 1'b1;

      if (issue)        req_q <= 1'b0;
      else if (req_evt) req_q <= 1'b1;

      if (cs_s) begin
        bit_cnt        <= '0;
        buf_full       <= 1'b0;
        req_q          <= 1'b0;
        spi_flash_miso <= 1'b0;
        out_cnt        <= '0;
      end else begin
        if (state == IDLE) bit_cnt <= '0;
        else if (sck_rise && ((state == CMD) || (state == ADDR))) begin
          in_sr   <= in_nxt;
          bit_cnt <= (cmd_done || addr_done) ? 5'd0 : bit_cnt + 5'd1;
        end

        if (addr_done) addr <= in_nxt[ADDR_W-1:0];

        if (load) begin
          spi_flash_miso <= load_byte[7];
          out_sr         <= {load_byte[6:0], 1'b0};
          out_cnt        <= '0;
          addr           <= addr_inc;
          buf_full       <= 1'b0;
        end else if (sck_fall && (state == DATA)) begin
          spi_flash_miso <= out_sr[7];
          out_sr         <= {out_sr[6:0], 1'b0};
          out_cnt        <= out_cnt + 3'd1;
        end

        if (rsp_ok && !load) begin
          nxt_byte <= mem_rd_rdata;
          buf_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: SPI master at clk/8 plus a byte memory returning
// addr[7:0]^0x5A, with an optional slow address to force an underrun.
module tb_spi_flash_resp;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        sck = 1'b0, cs = 1'b1, mosi = 1'b0, miso;
  logic        rd_valid, rd_ready = 1'b1, rvalid = 1'b0;
  logic [23:0] rd_addr;
  logic [7:0]  rdata = 8'h00;
  logic        busy, cmd_err, underrun;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  spi_flash_resp dut (
    .clk(clk), .rst_n(rst_n),
    .spi_flash_clk(sck), .spi_flash_cs(cs), .spi_flash_mosi(mosi), .spi_flash_miso(miso),
    .mem_rd_valid(rd_valid), .mem_rd_addr(rd_addr), .mem_rd_ready(rd_ready),
    .mem_rd_rvalid(rvalid), .mem_rd_rdata(rdata),
    .busy(busy), .cmd_err(cmd_err), .underrun(underrun)
  );

  // memory: one-cycle latency except for slow_addr (20 cycles)
  logic [23:0] req_log [0:63];
  int          req_n = 0, rsp_cnt = 0;
  logic [7:0]  rsp_data = 8'h00;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  always @(negedge clk) begin
    rvalid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin rvalid = 1'b1; rdata = rsp_data; end
    end
    if (rd_valid && rd_ready) begin
      if (req_n < 64) req_log[req_n] = rd_addr;
      req_n++;
      rsp_cnt  = ({8'h00, rd_addr} == slow_addr) ? 20 : 1;
      rsp_data = rd_addr[7:0] ^ 8'h5A;
    end
  end

  int cmd_err_n = 0, underrun_n = 0, valid_cyc = 0;
  always @(negedge clk) begin
    if (cmd_err)  cmd_err_n++;
    if (underrun) underrun_n++;
    if (rd_valid) valid_cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // each bit: SCK low + MOSI, half period, sample MISO, SCK high, half period
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sck = 1'b0; mosi = tx[i]; tick(4);
      rx[i] = miso; sck = 1'b1; tick(4);
    end
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    cs = 1'b0; tick(4);
    xfer(op, 8, d);
    xfer(a[23:16], 8, d);
    xfer(a[15:8], 8, d);
    xfer(a[7:0], 8, d);
  endtask

  // SCK drops together with CS, so that fall is never acted on
  task automatic stop();
    sck = 1'b0; cs = 1'b1; mosi = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b0, b1, b2;
    int rb, cb, ub, vb;

    tick(3);
    chk("rst_miso", miso, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1; tick(5);

    // basic read at 0x000100
    send_hdr(8'h03, 24'h000100);
    chk("t1_busy", busy, 1);
    xfer(8'h00, 8, b0); xfer(8'h00, 8, b1); xfer(8'h00, 8, b2);
    stop(); tick(10);
    chk("t1_b0", b0, 8'h5A);
    chk("t1_b1", b1, 8'h5B);
    chk("t1_b2", b2, 8'h58);
    chk("t1_nreq", req_n, 4);
    chk("t1_req0", req_log[0], 24'h000100);
    chk("t1_req1", req_log[1], 24'h000101);
    chk("t1_req2", req_log[2], 24'h000102);
    chk("t1_req3", req_log[3], 24'h000103);
    chk("t1_underrun", underrun_n, 0);
    chk("t1_cmd_err", cmd_err_n, 0);
    chk("t1_idle", busy, 0);

    // address wrap
    rb = req_n;
    send_hdr(8'h03, 24'hFFFFFF);
    xfer(8'h00, 8, b0); xfer(8'h00, 8, b1);
    stop(); tick(10);
    chk("wrap_b0", b0, 8'hA5);
    chk("wrap_b1", b1, 8'h5A);
    chk("wrap_req0", req_log[rb], 24'hFFFFFF);
    chk("wrap_req1", req_log[rb+1], 24'h000000);

    // unsupported opcode
    rb = req_n; cb = cmd_err_n;
    cs = 1'b0; tick(4);
    xfer(8'h9F, 8, b0);
    xfer(8'hAA, 8, b1);
    chk("bad_miso", b1, 8'h00);
    chk("bad_cmd_err", cmd_err_n - cb, 1);
    chk("bad_noreq", req_n - rb, 0);
    chk("bad_busy", busy, 1);
    stop(); tick(4);
    chk("bad_idle", busy, 0);
    tick(6);

    // first response too late: underrun then correct next byte
    rb = req_n; ub = underrun_n;
    slow_addr = 32'h0000_0020;
    send_hdr(8'h03, 24'h000020);
    xfer(8'h00, 8, b0); xfer(8'h00, 8, b1);
    stop(); tick(30);
    chk("ur_b0", b0, 8'hFF);
    chk("ur_b1", b1, 8'h7B);
    chk("ur_pulse", underrun_n - ub, 1);
    chk("ur_req0", req_log[rb], 24'h000020);
    chk("ur_req1", req_log[rb+1], 24'h000021);
    slow_addr = 32'hFFFF_FFFF;

    // abort mid-address with ready low, then a clean read
    rb = req_n; vb = valid_cyc;
    rd_ready = 1'b0;
    cs = 1'b0; tick(4);
    xfer(8'h03, 8, b0); xfer(8'h00, 8, b0); xfer(8'h00, 4, b0);
    stop(); tick(3);
    chk("abort_idle", busy, 0);
    tick(10);
    chk("abort_novalid", valid_cyc - vb, 0);
    rd_ready = 1'b1;
    send_hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, b0); xfer(8'h00, 8, b1);
    stop(); tick(10);
    chk("abort_b0", b0, 8'h4A);
    chk("abort_b1", b1, 8'h4B);
    chk("abort_req0", req_log[rb], 24'h000010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
